// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-FIFO-side signals of the TX arbiter.
// The requester/testbench side uses the master modport; the arbiter uses the slave modport.
interface uart_tx_arbiter_if #(
    parameter int BITS_d = 8,
    parameter int N_REQ  = 4
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*BITS_d-1:0] din;
    logic [N_REQ-1:0]        last;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        grant;
    logic [BITS_d-1:0]       w_data;
    logic                    wr_uart;
    logic                    tx_full;
    logic                    busy;
    logic                    timeout_err;

    modport master (
        output req, din, last, tx_full,
        input  ack, grant, w_data, wr_uart, busy, timeout_err
    );

    modport slave (
        input  req, din, last, tx_full,
        output ack, grant, w_data, wr_uart, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter feeding N_REQ byte streams into one UART TX FIFO.
// Define UART_ARB_TIMEOUT_EN to add a stall watchdog that force-releases a silent owner.
//
// state | meaning
// IDLE  | no owner; arbitrate among req, searching upward from ptr+1
// OWN   | grant held by one requester until it sends a byte with last
module uart_tx_arbiter #(
    parameter int BITS_d      = 8,
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_param_err
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic {IDLE, OWN} state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]    own_q, own_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic             busy_q, busy_d;

    logic [PW-1:0]     pick;
    logic              pick_vld;
    logic [PW-1:0]     idx;
    logic              req_g;
    logic              last_g;
    logic [BITS_d-1:0] din_g;
    logic              xfer;
    logic              rel;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
`endif

    // Descending scan so the candidate closest above ptr is the one that sticks.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = PW'((int'(ptr_q) + k) % N_REQ);
            if (bus.req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        req_g  = bus.req[own_q];
        last_g = bus.last[own_q];
        din_g  = bus.din[int'(own_q)*BITS_d +: BITS_d];
        xfer   = (state_q == OWN) && req_g && !bus.tx_full;
    end

    assign bus.wr_uart = xfer;
    assign bus.ack     = xfer ? grant_q : '0;
    assign bus.w_data  = (state_q == OWN) ? din_g : '0;
    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        rel     = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d        = OWN;
                    own_d          = pick;
                    grant_d        = '0;
                    grant_d[pick]  = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            OWN: begin
                if (xfer) begin
                    rel = last_g;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d = '0;
                end else if (!req_g) begin
                    if (cnt_q == TO_LAST) begin
                        rel       = 1'b1;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (rel) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = own_q;
        end
        busy_d = |grant_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            own_q   <= '0;
            ptr_q   <= PW'(N_REQ - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout_err = timeout_q;
`else
    assign bus.timeout_err = 1'b0;
`endif
endmodule
